// File: rtl/mole_spawn_ctrl.sv
// rtl/mole_spawn_ctrl.sv - mole generator and hit/miss judge; optional feature macro MOLE_WRONG_HIT_PENALTY_EN
module mole_spawn_ctrl #(
    parameter int NUM_HOLES    = 8,
    parameter int TICKS_PER_MS = 100000,
    parameter int UP_MS_D0     = 1500,
    parameter int UP_MS_D1     = 1000,
    parameter int UP_MS_D2     = 600,
    parameter int GAP_MS       = 400,
    parameter int FLASH_MS     = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_mole_ctrl,
    input  logic [1:0]           difficulty_level,
    input  logic [NUM_HOLES-1:0] hit_btn,
    output logic [NUM_HOLES-1:0] mole_leds,
    output logic                 mole_active,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam int HW = $clog2(NUM_HOLES);
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    // Durations are held as "last ms index" so a phase ends on the tick that completes it.
    localparam logic [PW-1:0] PS_LAST     = PW'(TICKS_PER_MS - 1);
    localparam logic [10:0]   GAP_LAST    = 11'(GAP_MS - 1);
    localparam logic [10:0]   FLASH_LAST  = 11'(FLASH_MS - 1);
    localparam logic [10:0]   UP_LAST_D0  = 11'(UP_MS_D0 - 1);
    localparam logic [10:0]   UP_LAST_D1  = 11'(UP_MS_D1 - 1);
    localparam logic [10:0]   UP_LAST_D2  = 11'(UP_MS_D2 - 1);

    typedef enum logic [1:0] {IDLE, GAP, UP, FLASH} state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [HW-1:0]   hole;        // current mole; doubles as the previous hole when picking the next
    logic [PW-1:0]   prescaler;
    logic [10:0]     ms_cnt;
    logic [10:0]     up_last;

    logic            tick;
    logic [PW-1:0]   ps_next;
    logic [10:0]     ms_next;
    logic [HW-1:0]   next_hole;
    logic [10:0]     up_last_sel;
    logic            hole_hit;
`ifdef MOLE_WRONG_HIT_PENALTY_EN
    logic            wrong_press;
`endif

    // Millisecond timebase, next-hole pick and press decode.
    always_comb begin
        tick        = (prescaler == PS_LAST);
        ps_next     = tick ? '0 : prescaler + 1'b1;
        ms_next     = tick ? ms_cnt + 11'd1 : ms_cnt;
        next_hole   = (lfsr[HW-1:0] == hole) ? lfsr[HW-1:0] + 1'b1 : lfsr[HW-1:0];
        case (difficulty_level)
            2'd0:    up_last_sel = UP_LAST_D0;
            2'd1:    up_last_sel = UP_LAST_D1;
            default: up_last_sel = UP_LAST_D2;
        endcase
        hole_hit    = hit_btn[hole];
`ifdef MOLE_WRONG_HIT_PENALTY_EN
        wrong_press = |(hit_btn & ~(NUM_HOLES'(1) << hole));
`endif
    end

    // Free-running Fibonacci LFSR (taps 16,14,13,11); nonzero seed keeps it off the all-zero state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Mole FSM with registered LEDs and pulses; disable overrides every other decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hole        <= '0;
            prescaler   <= '0;
            ms_cnt      <= '0;
            up_last     <= UP_LAST_D0;
            mole_leds   <= '0;
            mole_active <= 1'b0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (!enable_mole_ctrl) begin
                state       <= IDLE;
                prescaler   <= '0;
                ms_cnt      <= '0;
                mole_leds   <= '0;
                mole_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= GAP;
                        prescaler <= '0;
                        ms_cnt    <= '0;
                    end
                    GAP: begin
                        if (tick && ms_cnt == GAP_LAST) begin
                            state       <= UP;
                            hole        <= next_hole;
                            up_last     <= up_last_sel;
                            mole_leds   <= NUM_HOLES'(1) << next_hole;
                            mole_active <= 1'b1;
                            prescaler   <= '0;
                            ms_cnt      <= '0;
                        end else begin
                            prescaler <= ps_next;
                            ms_cnt    <= ms_next;
                        end
                    end
                    UP: begin
                        if (hole_hit) begin
                            state       <= FLASH;
                            hit_pulse   <= 1'b1;
                            mole_leds   <= '1;
                            mole_active <= 1'b0;
                            prescaler   <= '0;
                            ms_cnt      <= '0;
                        end else if (tick && ms_cnt == up_last) begin
                            state       <= GAP;
                            miss_pulse  <= 1'b1;
                            mole_leds   <= '0;
                            mole_active <= 1'b0;
                            prescaler   <= '0;
                            ms_cnt      <= '0;
                        end else begin
                            prescaler <= ps_next;
                            ms_cnt    <= ms_next;
`ifdef MOLE_WRONG_HIT_PENALTY_EN
                            if (wrong_press) begin
                                miss_pulse <= 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        if (tick && ms_cnt == FLASH_LAST) begin
                            state     <= GAP;
                            mole_leds <= '0;
                            prescaler <= '0;
                            ms_cnt    <= '0;
                        end else begin
                            prescaler <= ps_next;
                            ms_cnt    <= ms_next;
                        end
                    end
                endcase
            end
        end
    end

endmodule
